// File: rtl/checkout_pkg.sv
// Shared types and constants for the checkout-lane controller.
// Latency: none. This file holds declarations only.
// Backpressure: not applicable.
package checkout_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLASSIFY = 2'd1,
        ALARM    = 2'd2,
        DONE     = 2'd3
    } chk_state_t;

    // Bit positions inside the {U,P,C} field
    localparam int U_BIT = 2;
    localparam int P_BIT = 1;
    localparam int C_BIT = 0;

endpackage

// File: rtl/upc_classifier.sv
// Maps one captured item (UPC field plus security mark) to its stolen and discount flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none. The caller decides when the result is consumed.
module upc_classifier
    import checkout_pkg::*;
(
    input  logic [2:0] i_upc,
    input  logic       i_mark,
    output logic       o_stolen,
    output logic       o_disc
);

    logic w_u;
    logic w_p;
    logic w_c;

    assign w_u = i_upc[U_BIT];
    assign w_p = i_upc[P_BIT];
    assign w_c = i_upc[C_BIT];

    // An item is stolen only when the mark is missing and the code is one of the unpaid patterns
    assign o_stolen = ~i_mark & ((w_u & ~w_p) | (~w_u & ~w_c));
    assign o_disc   = w_p | (w_u & w_c);

endmodule

// File: rtl/checkout_controller.sv
// Runs one checkout lane: captures items, classifies them, counts them per transaction, and raises the stolen alarm.
// Latency: counters update 2 edges after a scan is accepted. The alarm rises on that same edge. Throughput is one item per 2 cycles.
// Backpressure: scan_ready is high only in IDLE. Scans are refused during classify, alarm and done.
module checkout_controller
    import checkout_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int ALARM_HOLD = 8
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_valid,
    output logic             scan_ready,
    input  logic [2:0]       upc,
    input  logic             mark,
    input  logic             checkout,
    input  logic             alarm_clr,
    output logic             alarm,
    output logic             done,
    output logic [CNT_W-1:0] item_count,
    output logic [CNT_W-1:0] stolen_count,
    output logic [CNT_W-1:0] discount_count
);

    localparam logic [7:0] HOLD_INIT = 8'(ALARM_HOLD - 1);

    chk_state_t       r_state;
    chk_state_t       w_next_state;
    logic [2:0]       r_upc;
    logic             r_mark;
    logic [7:0]       r_hold;
    logic             r_clr_pend;
    logic             r_alarm;
    logic             r_done;
    logic [CNT_W-1:0] r_item;
    logic [CNT_W-1:0] r_stolen;
    logic [CNT_W-1:0] r_disc;

    logic             w_accept;
    logic             w_stolen;
    logic             w_disc;
    logic [CNT_W-1:0] w_base_item;
    logic [CNT_W-1:0] w_base_stolen;
    logic [CNT_W-1:0] w_base_disc;

    // Counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + 1'b1;
        end
        return v;
    endfunction

    upc_classifier u_classifier (
        .i_upc    (r_upc),
        .i_mark   (r_mark),
        .o_stolen (w_stolen),
        .o_disc   (w_disc)
    );

    assign scan_ready = (r_state == IDLE);
    assign w_accept   = scan_valid & scan_ready;

    // The first item after a closed transaction counts from zero rather than from the held totals
    assign w_base_item   = r_clr_pend ? '0 : r_item;
    assign w_base_stolen = r_clr_pend ? '0 : r_stolen;
    assign w_base_disc   = r_clr_pend ? '0 : r_disc;

    // Next-state decode; a scan beats a simultaneous checkout, which is then dropped
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = CLASSIFY;
                end else if (checkout) begin
                    w_next_state = DONE;
                end
            end
            CLASSIFY: w_next_state = w_stolen ? ALARM : IDLE;
            ALARM: begin
                if ((r_hold == 8'd0) && alarm_clr) begin
                    w_next_state = IDLE;
                end
            end
            DONE:     w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    // State register, with alarm and done registered from the next state so both stay glitch-free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_alarm <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_alarm <= (w_next_state == ALARM);
            r_done  <= (w_next_state == DONE);
        end
    end

    // Capture the item on the handshake edge; the classifier works on this copy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_upc  <= 3'b000;
            r_mark <= 1'b0;
        end else if (w_accept) begin
            r_upc  <= upc;
            r_mark <= mark;
        end
    end

    // The hold timer loads on ALARM entry and counts down to zero. alarm_clr only matters once it reaches zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold <= 8'd0;
        end else if ((r_state == CLASSIFY) && w_stolen) begin
            r_hold <= HOLD_INIT;
        end else if ((r_state == ALARM) && (r_hold != 8'd0)) begin
            r_hold <= r_hold - 8'd1;
        end
    end

    // A closed transaction arms a clear that the next classified item consumes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clr_pend <= 1'b0;
        end else if (r_state == DONE) begin
            r_clr_pend <= 1'b1;
        end else if (r_state == CLASSIFY) begin
            r_clr_pend <= 1'b0;
        end
    end

    // Per-transaction counters update only in CLASSIFY and hold otherwise, so totals stay readable after done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_item   <= '0;
            r_stolen <= '0;
            r_disc   <= '0;
        end else if (r_state == CLASSIFY) begin
            r_item   <= sat_inc(w_base_item, 1'b1);
            r_stolen <= sat_inc(w_base_stolen, w_stolen);
            r_disc   <= sat_inc(w_base_disc, w_disc);
        end
    end

    assign alarm          = r_alarm;
    assign done           = r_done;
    assign item_count     = r_item;
    assign stolen_count   = r_stolen;
    assign discount_count = r_disc;

endmodule
